// File: rtl/spn_pkg.sv
// spn_pkg: shared types and sizes for the streaming permutation network
// receive side.
//   PARA            lanes per beat
//   DATA_WIDTH      bits per lane element
//   FRAME_BEATS     beats per frame (16x16 matrix / PARA)
//   BEAT_ADDR_WIDTH log2(FRAME_BEATS)
//   lane_t / beat_t one lane element / one PARA-lane beat
//   rd_state_t      replay FSM states
package spn_pkg;

  localparam int unsigned PARA            = 4;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned FRAME_BEATS     = 64;
  localparam int unsigned BEAT_ADDR_WIDTH = 6;

  typedef logic [DATA_WIDTH-1:0]      lane_t;
  typedef lane_t [PARA-1:0]           beat_t;
  typedef logic [BEAT_ADDR_WIDTH-1:0] beat_addr_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PRIME,
    RD_STREAM
  } rd_state_t;

  localparam beat_addr_t LAST_BEAT = beat_addr_t'(FRAME_BEATS - 1);

endpackage

// File: rtl/spn_sink_bank.sv
// spn_sink_bank: one frame bank. Simple dual-port RAM, FRAME_BEATS x beat_t,
// one write port and one registered read port (1-cycle latency). Contents
// are never reset.
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write beat address
//   wr_data  beat to store
//   rd_en    read strobe; rd_data updates on the following edge
//   rd_addr  read beat address
//   rd_data  registered read data
module spn_sink_bank
  import spn_pkg::*;
(
  input  logic       clk,
  input  logic       wr_en,
  input  beat_addr_t wr_addr,
  input  beat_t      wr_data,
  input  logic       rd_en,
  input  beat_addr_t rd_addr,
  output beat_t      rd_data
);

  beat_t mem [FRAME_BEATS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/spn_stream_sink.sv
// spn_stream_sink: receive-side endpoint of the streaming permutation network.
// Discards the leading flush frame(s), assembles complete frames into a
// ping-pong pair of banks and replays them on a ready/valid interface.
//   clk            clock, all logic on posedge
//   rst            asynchronous active-low reset
//   valid_in       beat strobe from spn
//   stream_in      PARA-lane beat from spn
//   out_valid      out_data holds a valid beat
//   out_ready      downstream accepts the beat
//   out_data       replayed beat, lane order preserved
//   out_last       marks beat FRAME_BEATS-1 of a frame
//   frame_done     one-cycle pulse when a frame is committed to a bank
//   overflow       sticky, set when a frame is dropped
//   frames_dropped saturating count of dropped frames
module spn_stream_sink
  import spn_pkg::*;
#(
  parameter int unsigned SKIP_FRAMES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  beat_t      stream_in,
  output logic       out_valid,
  input  logic       out_ready,
  output beat_t      out_data,
  output logic       out_last,
  output logic       frame_done,
  output logic       overflow,
  output logic [7:0] frames_dropped
);

  localparam int unsigned SKIP_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES + 1) : 1;

  // ---------------- write side state ----------------
  beat_addr_t        wr_beat;
  logic              wr_bank;
  logic [SKIP_W-1:0] skip_cnt;
  logic              dropping;
  logic [1:0]        full;
  logic [1:0]        full_next;

  // ---------------- read side state ----------------
  rd_state_t  state;
  logic       rd_bank;
  beat_addr_t rd_addr;
  logic       issued_all;
  logic       ram_vld;
  logic       ram_bank;
  logic       ram_last;
  logic [1:0] count;
  beat_t      skid1;
  logic       last1;

  // ---------------- combinational controls ----------------
  logic       at_first, at_last, skipping, bypass, drop_now, wr_en, commit;
  logic       pop, push, space, release_bank, other_full;
  logic [1:0] count_next;
  logic       issue, issue_bank;
  beat_addr_t issue_addr;
  beat_t      ram_data, rd_data_ping, rd_data_pong;

  assign pop          = out_valid && out_ready;
  assign push         = ram_vld;
  assign count_next   = count + {1'b0, push} - {1'b0, pop};
  // A read issued now lands in the skid one edge later; it must fit even
  // if nothing is popped in between.
  assign space        = count_next < 2'd2;
  assign release_bank = (state == RD_STREAM) && pop && out_last;

  assign at_first = (wr_beat == '0);
  assign at_last  = (wr_beat == LAST_BEAT);
  assign skipping = (skip_cnt != '0);
  // A bank freed by the read side in this very cycle counts as empty.
  assign bypass   = release_bank && (rd_bank == wr_bank);
  assign drop_now = at_first ? (!skipping && full[wr_bank] && !bypass) : dropping;
  assign wr_en    = valid_in && !skipping && !drop_now;
  assign commit   = wr_en && at_last;

  // Commit into the other bank in the same cycle lets the replay chain
  // straight on without passing through idle.
  assign other_full = full[~rd_bank] || (commit && (wr_bank != rd_bank));

  always_comb begin
    full_next = full;
    if (release_bank) full_next[rd_bank] = 1'b0;
    if (commit)       full_next[wr_bank] = 1'b1;
  end

  always_comb begin
    issue      = 1'b0;
    issue_bank = rd_bank;
    issue_addr = rd_addr;
    unique case (state)
      RD_IDLE: begin
        issue      = full[rd_bank];
        issue_addr = '0;
      end
      RD_PRIME, RD_STREAM: begin
        if (release_bank) begin
          issue      = other_full;
          issue_bank = ~rd_bank;
          issue_addr = '0;
        end else begin
          issue = space && !issued_all;
        end
      end
      default: issue = 1'b0;
    endcase
  end

  // ---------------- write side ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_beat        <= '0;
      wr_bank        <= 1'b0;
      skip_cnt       <= SKIP_W'(SKIP_FRAMES);
      dropping       <= 1'b0;
      full           <= '0;
      frame_done     <= 1'b0;
      overflow       <= 1'b0;
      frames_dropped <= '0;
    end else begin
      frame_done <= commit;
      full       <= full_next;
      if (valid_in) begin
        wr_beat <= at_last ? '0 : wr_beat + 1'b1;
        if (at_first) dropping <= drop_now;
        if (at_last && skipping) skip_cnt <= skip_cnt - 1'b1;
        if (commit) wr_bank <= ~wr_bank;
        if (at_first && drop_now) begin
          overflow <= 1'b1;
          if (frames_dropped != '1) frames_dropped <= frames_dropped + 1'b1;
        end
      end
    end
  end

  // ---------------- banks ----------------
  spn_sink_bank u_ping (
    .clk     (clk),
    .wr_en   (wr_en && (wr_bank == 1'b0)),
    .wr_addr (wr_beat),
    .wr_data (stream_in),
    .rd_en   (issue && (issue_bank == 1'b0)),
    .rd_addr (issue_addr),
    .rd_data (rd_data_ping)
  );

  spn_sink_bank u_pong (
    .clk     (clk),
    .wr_en   (wr_en && (wr_bank == 1'b1)),
    .wr_addr (wr_beat),
    .wr_data (stream_in),
    .rd_en   (issue && (issue_bank == 1'b1)),
    .rd_addr (issue_addr),
    .rd_data (rd_data_pong)
  );

  assign ram_data = ram_bank ? rd_data_pong : rd_data_ping;

  // ---------------- read FSM, skid buffer and outputs ----------------
  // out_data/out_last form the head of the 2-entry skid; skid1 is the tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RD_IDLE;
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
      issued_all <= 1'b0;
      ram_vld    <= 1'b0;
      ram_bank   <= 1'b0;
      ram_last   <= 1'b0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      skid1      <= '0;
      last1      <= 1'b0;
    end else begin
      ram_vld <= issue;
      if (issue) begin
        ram_bank   <= issue_bank;
        ram_last   <= (issue_addr == LAST_BEAT);
        issued_all <= (issue_addr == LAST_BEAT);
        rd_addr    <= issue_addr + 1'b1;
      end

      count     <= count_next;
      out_valid <= (count_next != '0);
      if (pop) begin
        if (count == 2'd2) begin
          out_data <= skid1;
          out_last <= last1;
          if (push) begin
            skid1 <= ram_data;
            last1 <= ram_last;
          end
        end else if (push) begin
          out_data <= ram_data;
          out_last <= ram_last;
        end
      end else if (push) begin
        if (count == '0) begin
          out_data <= ram_data;
          out_last <= ram_last;
        end else begin
          skid1 <= ram_data;
          last1 <= ram_last;
        end
      end

      unique case (state)
        RD_IDLE:   if (full[rd_bank]) state <= RD_PRIME;
        RD_PRIME:  state <= RD_STREAM;
        RD_STREAM: begin
          if (release_bank) begin
            rd_bank <= ~rd_bank;
            state   <= other_full ? RD_PRIME : RD_IDLE;
          end
        end
        default:   state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spn_stream_sink.sv
module tb_spn_stream_sink;
  import spn_pkg::*;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       valid_in  = 1'b0;
  logic       out_ready = 1'b0;
  beat_t      stream_in = '0;
  logic       out_valid, out_last, frame_done, overflow;
  beat_t      out_data;
  logic [7:0] frames_dropped;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          ready_mode = 0;  // 0 high, 1 low, 2 toggle, 3 random

  always #5 clk = ~clk;

  spn_stream_sink #(.SKIP_FRAMES(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .valid_in       (valid_in),
    .stream_in      (stream_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .frame_done     (frame_done),
    .overflow       (overflow),
    .frames_dropped (frames_dropped)
  );

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed { beat_t data; logic last; } exp_t;
  exp_t  exp_q[$];
  beat_t m_frame [FRAME_BEATS];
  int    m_beat, m_skip, m_held, m_mode, m_drops, m_hs;
  logic  m_ovf, m_fd;
  logic  stall_prev;
  beat_t stall_data;
  logic  stall_last;

  // Runs at negedge: inputs and outputs are stable and describe what the
  // next posedge will do.
  always @(negedge clk) begin
    exp_t e;
    logic rel;
    if (!rst) begin
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      check("reset out_last", out_last, 0);
      check("reset frame_done", frame_done, 0);
      check("reset overflow", overflow, 0);
      check("reset frames_dropped", frames_dropped, 0);
      exp_q.delete();
      m_beat = 0; m_skip = 1; m_held = 0; m_mode = 0; m_drops = 0; m_hs = 0;
      m_ovf = 1'b0; m_fd = 1'b0; stall_prev = 1'b0;
    end else begin
      check("frame_done", frame_done, m_fd);
      check("overflow", overflow, m_ovf);
      check("frames_dropped", frames_dropped, m_drops);
      if (stall_prev) begin
        check("hold valid", out_valid, 1);
        check("hold data", out_data, stall_data);
        check("hold last", out_last, stall_last);
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;

      rel = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected beat", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
        end
        m_hs++;
        if (m_hs % FRAME_BEATS == 0) rel = 1'b1;
      end
      if (rel) m_held--;

      m_fd = 1'b0;
      if (valid_in) begin
        if (m_beat == 0) begin
          if (m_skip > 0) m_mode = 1;
          else if (m_held == 2) begin
            m_mode = 2;
            m_ovf  = 1'b1;
            if (m_drops < 255) m_drops++;
          end else m_mode = 0;
        end
        if (m_mode == 0) m_frame[m_beat] = stream_in;
        if (m_beat == FRAME_BEATS - 1) begin
          if (m_mode == 1) m_skip--;
          else if (m_mode == 0) begin
            for (int i = 0; i < FRAME_BEATS; i++) exp_q.push_back({m_frame[i], i == FRAME_BEATS - 1});
            m_held++;
            m_fd = 1'b1;
          end
        end
        m_beat = (m_beat + 1) % FRAME_BEATS;
      end
    end
  end

  // ---------------- ready driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        2:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // ---------------- stimulus helpers (all entered/left at posedge+1) ----------------
  task automatic send_beats(input int pattern, input int gap_pct, input int n);
    for (int b = 0; b < n; b++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
      end
      valid_in = 1'b1;
      for (int l = 0; l < PARA; l++)
        stream_in[l] = (pattern != 0) ? lane_t'(b * 4 + l) : lane_t'($urandom);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
  endtask

  task automatic send_frame(input int pattern, input int gap_pct);
    send_beats(pattern, gap_pct, FRAME_BEATS);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain complete", exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Flush frame discarded, second frame replayed; fill-to-output latency.
    ready_mode = 0;
    send_frame(1, 0);
    send_frame(1, 0);
    cyc = 0;
    @(negedge clk);
    while (!frame_done && cyc < 4) begin @(negedge clk); cyc++; end
    check("frame_done seen", frame_done, 1);
    @(negedge clk);
    check("fill latency idle", out_valid, 0);
    @(negedge clk);
    check("fill latency valid", out_valid, 1);
    @(posedge clk); #1;
    drain();

    // Toggling ready during replay.
    ready_mode = 2;
    send_frame(1, 0);
    drain();

    // Both banks fill, next two frames dropped.
    ready_mode = 1;
    @(posedge clk); #1;
    repeat (4) send_frame(0, 0);
    @(negedge clk);
    check("overflow after drops", overflow, 1);
    check("dropped count", frames_dropped, 2);
    @(posedge clk); #1;
    ready_mode = 0;
    drain();

    // Beat 0 arrives in the cycle the out_last handshake frees the bank.
    do_reset();
    ready_mode = 1;
    @(posedge clk); #1;
    send_frame(0, 0);
    send_frame(1, 0);
    send_frame(0, 0);
    ready_mode = 0;
    cyc = 0;
    while (!(out_valid && out_last && out_ready) && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bypass alignment reached", cyc < 500, 1);
    send_frame(0, 0);
    @(negedge clk);
    check("bypass no overflow", overflow, 0);
    check("bypass no drops", frames_dropped, 0);
    @(posedge clk); #1;
    drain();

    // Random gaps on valid_in, random ready.
    ready_mode = 3;
    send_frame(1, 50);
    send_frame(0, 50);
    send_frame(0, 30);
    ready_mode = 0;
    drain();

    // Reset mid-frame with a stored frame pending.
    ready_mode = 1;
    @(posedge clk); #1;
    send_frame(0, 0);
    send_beats(0, 0, 30);
    do_reset();
    ready_mode = 0;
    send_frame(0, 0);
    send_frame(1, 0);
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("no stale output", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
